// File: rtl/inst_mem_pkg.sv
// Shared constants and state encoding for the instruction-memory AXI read slave.
package inst_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

endpackage

// File: rtl/inst_mem_axi_rd_slave_if.sv
// AXI4 read-address and read-data channels between the fetch-side master and the RAM slave.
interface inst_mem_axi_rd_slave_if #(
    parameter int ID_W   = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/inst_mem_ram.sv
// Simple dual-port RAM: synchronous preload write, synchronous read with one cycle latency.
// A read and write to the same word in one cycle returns the old contents.
module inst_mem_ram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Storage is intentionally not reset; contents come from the preload port.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/inst_mem_axi_rd_slave.sv
// AXI4 read-only slave serving instruction fetch bursts from on-chip RAM.
// Optional macro INST_MEM_OOR_SLVERR_EN: beats addressing outside the RAM window
// return SLVERR with zero data; otherwise the word index simply wraps.
module inst_mem_axi_rd_slave
    import inst_mem_pkg::*;
#(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_MEM_WORDS_LOG2   = 12,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = 32'h2000_0000
) (
    input  logic                          aclk,
    input  logic                          arst,
    inst_mem_axi_rd_slave_if.slave        s_axi,
    input  logic                          mem_we,
    input  logic [C_MEM_WORDS_LOG2-1:0]   mem_waddr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] mem_wdata
);
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;

    state_t                    state_q, state_d;
    logic                      arready_q;
    logic [C_S_AXI_ID_WIDTH-1:0] id_q;
    logic [7:0]                len_q, beat_q;
    logic                      incr_q;
    logic [AW-1:0]             ofs_q;
    logic [8:0]                iss_q;
    logic                      rd_vld_q, rd_oor_q;
    logic [DW-1:0]             fd_q [2];
    logic [1:0]                fr_q [2];
    logic                      wp_q, rp_q;
    logic [1:0]                cnt_q;

    logic          ar_hs, pop, rvalid, rlast, credit_ok, issue, issue_oor, step;
    logic [AW-1:0] start_ofs, rd_ofs;
    logic [DW-1:0] ram_dout;

    assign ar_hs     = (state_q == ST_IDLE) && s_axi.arvalid && arready_q;
    assign start_ofs = (s_axi.araddr - C_BASE_ADDR) >> 2;
    assign rvalid    = (cnt_q != 2'd0);
    assign pop       = rvalid && s_axi.rready;
    assign rlast     = rvalid && (beat_q == len_q);
    // A new read may only launch if its data is guaranteed a skid slot when it lands.
    assign credit_ok = ({1'b0, cnt_q} + {2'b00, rd_vld_q}) <= ({2'b00, pop} + 3'd1);
    assign issue     = ar_hs || ((state_q == ST_BURST) && (iss_q <= {1'b0, len_q}) && credit_ok);
    assign rd_ofs    = ar_hs ? start_ofs : ofs_q;
    assign step      = ar_hs ? (s_axi.arburst != BURST_FIXED) : incr_q;
`ifdef INST_MEM_OOR_SLVERR_EN
    assign issue_oor = (rd_ofs >= AW'(2**C_MEM_WORDS_LOG2));
`else
    assign issue_oor = 1'b0;
`endif

    inst_mem_ram #(.ADDR_W(C_MEM_WORDS_LOG2), .DATA_W(DW)) u_ram (
        .clk   (aclk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (issue),
        .raddr (rd_ofs[C_MEM_WORDS_LOG2-1:0]),
        .rdata (ram_dout)
    );

    // Next-state: one outstanding burst, back to idle on the final beat handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (ar_hs) state_d = ST_BURST;
            ST_BURST: if (pop && rlast) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register plus burst context, address generator and read pipeline.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q   <= ST_IDLE;
            arready_q <= 1'b0;
            id_q      <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            incr_q    <= 1'b0;
            ofs_q     <= '0;
            iss_q     <= '0;
            rd_vld_q  <= 1'b0;
            rd_oor_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            arready_q <= (state_d == ST_IDLE);
            rd_vld_q  <= issue;
            rd_oor_q  <= issue && issue_oor;
            if (pop) beat_q <= beat_q + 8'd1;
            if (issue) begin
                ofs_q <= rd_ofs + {{(AW-1){1'b0}}, step};
                iss_q <= iss_q + 9'd1;
            end
            if (ar_hs) begin
                id_q   <= s_axi.arid;
                len_q  <= s_axi.arlen;
                incr_q <= (s_axi.arburst != BURST_FIXED);
                beat_q <= '0;
                iss_q  <= 9'd1;
            end
        end
    end

    // Two-entry skid buffer; its head drives the R channel and stays put while stalled.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            fd_q  <= '{default: '0};
            fr_q  <= '{default: '0};
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (rd_vld_q) begin
                fd_q[wp_q] <= rd_oor_q ? '0 : ram_dout;
                fr_q[wp_q] <= rd_oor_q ? RESP_SLVERR : RESP_OKAY;
                wp_q       <= ~wp_q;
            end
            if (pop) rp_q <= ~rp_q;
            cnt_q <= cnt_q + {1'b0, rd_vld_q} - {1'b0, pop};
        end
    end

    assign s_axi.arready = arready_q;
    assign s_axi.rid     = id_q;
    assign s_axi.rdata   = fd_q[rp_q];
    assign s_axi.rresp   = fr_q[rp_q];
    assign s_axi.rvalid  = rvalid;
    assign s_axi.rlast   = rlast;
endmodule

// File: tb/tb_inst_mem_axi_rd_slave.sv
// Scoreboard bench for the instruction-memory AXI read slave.
module tb_inst_mem_axi_rd_slave;
    logic        clk = 1'b0;
    logic        arst;
    logic        mem_we;
    logic [11:0] mem_waddr;
    logic [31:0] mem_wdata;

    always #5 clk = ~clk;

    inst_mem_axi_rd_slave_if #(.ID_W(1), .ADDR_W(32), .DATA_W(32)) axi ();

    inst_mem_axi_rd_slave dut (
        .aclk      (clk),
        .arst      (arst),
        .s_axi     (axi),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic        id;
    } beat_t;

    beat_t sb[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    hs_cyc = 0;
    int    last_cyc = 0;
    int    nbeats = 0;
    bit    chk_first = 0;
    bit    stall_prev = 0;
    logic [35:0] stall_val;
    bit    rr_mode = 0;
    logic [3:0] rr_pat = 4'b1001;
    int    rr_k = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_burst(input logic id, input int start, input int len, input bit fixed);
        beat_t b;
        for (int i = 0; i <= len; i++) begin
            b.data = 32'hA000_0000 + 32'(fixed ? start : ((start + i) % 4096));
            b.resp = 2'b00;
            b.last = (i == len);
            b.id   = id;
            sb.push_back(b);
        end
    endtask

    task automatic do_ar(input logic id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
        bit done;
        done = 0;
        @(negedge clk);
        axi.arid    = id;
        axi.araddr  = addr;
        axi.arlen   = len;
        axi.arsize  = 3'b010;
        axi.arburst = burst;
        axi.arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (axi.arready) begin
                @(posedge clk);
                @(negedge clk);
                hs_cyc    = cyc;
                chk_first = 1;
                done      = 1;
                break;
            end
            @(negedge clk);
        end
        axi.arvalid = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL ar_timeout: arready never seen for addr %0h", addr);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    always @(posedge clk) cyc++;

    // Ready pattern driven just after the edge so the negedge monitor sees it stable.
    always @(posedge clk) begin
        #1;
        if (rr_mode) begin
            axi.rready = rr_pat[rr_k];
            rr_k = (rr_k + 1) % 4;
        end else begin
            axi.rready = 1'b1;
        end
    end

    // Monitor: checks held data under stall, first-beat latency and every accepted beat.
    always @(negedge clk) begin
        beat_t e;
        if (!arst) begin
            if (stall_prev)
                chk("stall_hold", {28'd0, axi.rvalid, axi.rlast, axi.rresp, axi.rdata[31:0]},
                    {28'd0, stall_val});
            if (axi.rvalid && chk_first) begin
                chk("first_lat", 64'(cyc - hs_cyc), 64'd1);
                chk_first = 0;
            end
            if (axi.rvalid && axi.rready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL beat_extra: got %0h expected none", axi.rdata);
                end else begin
                    e = sb.pop_front();
                    chk("beat", {28'd0, axi.rid, axi.rlast, axi.rresp, axi.rdata},
                        {28'd0, e.id, e.last, e.resp, e.data});
                end
                nbeats++;
                if (axi.rlast) last_cyc = cyc;
            end
            stall_prev = axi.rvalid && !axi.rready;
            stall_val  = {axi.rvalid, axi.rlast, axi.rresp, axi.rdata};
        end else begin
            stall_prev = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t b;
        int    target;
        arst        = 1'b1;
        mem_we      = 1'b0;
        mem_waddr   = '0;
        mem_wdata   = '0;
        axi.arvalid = 1'b0;
        axi.arid    = '0;
        axi.araddr  = '0;
        axi.arlen   = '0;
        axi.arsize  = 3'b010;
        axi.arburst = 2'b01;
        axi.rready  = 1'b1;

        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            mem_we    = 1'b1;
            mem_waddr = 12'(i);
            mem_wdata = 32'hA000_0000 + 32'(i);
        end
        @(negedge clk);
        mem_we = 1'b0;

        @(negedge clk);
        arst = 1'b0;
        #1;
        chk("rst_arready", 64'(axi.arready), 64'd0);
        chk("rst_rvalid", 64'(axi.rvalid), 64'd0);
        chk("rst_rout", {28'd0, axi.rid, axi.rlast, axi.rresp, axi.rdata}, 64'd0);
        @(negedge clk);
        chk("arready_up", 64'(axi.arready), 64'd1);

        push_burst(1'b0, 0, 31, 1'b0);
        do_ar(1'b0, 32'h2000_0000, 8'd31, 2'b01);
        wait_drain();
        chk("burst_end", 64'(last_cyc - hs_cyc), 64'd32);

        rr_mode = 1;
        push_burst(1'b1, 0, 31, 1'b0);
        do_ar(1'b1, 32'h2000_0000, 8'd31, 2'b01);
        wait_drain();
        rr_mode = 0;

        push_burst(1'b0, 4095, 0, 1'b0);
        b.id = 1'b0;
        b.last = 1'b1;
`ifdef INST_MEM_OOR_SLVERR_EN
        b.data = 32'h0;
        b.resp = 2'b10;
`else
        b.data = 32'hA000_0000;
        b.resp = 2'b00;
`endif
        sb[0].last = 1'b0;
        sb.push_back(b);
        do_ar(1'b0, 32'h2000_3FFC, 8'd1, 2'b01);
        wait_drain();

        push_burst(1'b1, 4, 3, 1'b1);
        do_ar(1'b1, 32'h2000_0010, 8'd3, 2'b00);
        wait_drain();

        push_burst(1'b0, 0, 31, 1'b0);
        target = nbeats + 10;
        do_ar(1'b0, 32'h2000_0000, 8'd31, 2'b01);
        for (int i = 0; i < 100; i++) begin
            if (nbeats >= target) break;
            @(negedge clk);
        end
        arst = 1'b1;
        #1;
        chk("abort_rvalid", 64'(axi.rvalid), 64'd0);
        chk("abort_rlast", 64'(axi.rlast), 64'd0);
        chk("abort_arready", 64'(axi.arready), 64'd0);
        chk("abort_beats", 64'(nbeats >= target), 64'd1);
        sb.delete();
        chk_first = 0;
        repeat (2) @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        push_burst(1'b0, 32, 0, 1'b0);
        do_ar(1'b0, 32'h2000_0080, 8'd0, 2'b01);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
